// File: rtl/lstm_window_feeder.sv
// Input sequencer for the LSTM forward datapath: reads samples from the sample
// memory and hands sliding windows of WIN samples, advanced by a stride, to the core.
module lstm_window_feeder #(
  parameter int WIDTH  = 32,
  parameter int CH     = 1,
  parameter int WIN    = 34,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [ADDR_W-1:0]       i_base,
  input  logic [ADDR_W-1:0]       i_len,
  input  logic [ADDR_W-1:0]       i_stride,
  output logic                    o_rd_en,
  output logic [ADDR_W-1:0]       o_addr,
  input  logic [CH*WIDTH-1:0]     i_rd_data,
  output logic [WIN*CH*WIDTH-1:0] o_x,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [CNT_W-1:0]        o_win_cnt
);
  // state | meaning
  // IDLE  | waiting for i_start
  // FILL  | reading the first WIN samples of the run
  // EMIT  | complete window presented, waiting for i_ready
  // STEP  | reading stride samples to slide the window
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, FILL, EMIT, STEP, DONE} state_t;

  localparam int SW       = CH * WIDTH;
  localparam int XW       = WIN * SW;
  localparam int WIN_BITS = $clog2(WIN + 1);
  localparam int RC_W     = (ADDR_W > WIN_BITS) ? ADDR_W : WIN_BITS;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] rd_off;
  logic [RC_W-1:0]   issue_left;
  logic [RC_W-1:0]   cap_left;
  logic              rd_pend;
  logic [ADDR_W:0]   next_end;
  logic              short_len;

  // rd_off is the offset of the next read, i.e. one past the newest sample held
  assign next_end  = {1'b0, rd_off} + {1'b0, stride_q};
  assign short_len = 32'(i_len) < 32'(WIN);
  assign o_busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      stride_q   <= '0;
      rd_off     <= '0;
      issue_left <= '0;
      cap_left   <= '0;
      rd_pend    <= 1'b0;
      o_rd_en    <= 1'b0;
      o_addr     <= '0;
      o_x        <= '0;
      o_valid    <= 1'b0;
      o_done     <= 1'b0;
      o_win_cnt  <= '0;
    end else if (i_abort) begin
      // in-flight read data is dropped by clearing rd_pend
      state      <= IDLE;
      issue_left <= '0;
      cap_left   <= '0;
      rd_pend    <= 1'b0;
      o_rd_en    <= 1'b0;
      o_valid    <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      rd_pend <= o_rd_en;
      o_done  <= 1'b0;
      case (state)
        IDLE: begin
          o_rd_en <= 1'b0;
          if (i_start) begin
            base_q    <= i_base;
            len_q     <= i_len;
            stride_q  <= (i_stride == '0) ? ADDR_W'(1) : i_stride;
            o_x       <= '0;
            o_win_cnt <= '0;
            if (short_len) begin
              rd_off <= '0;
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              o_rd_en    <= 1'b1;
              o_addr     <= i_base;
              rd_off     <= ADDR_W'(1);
              issue_left <= RC_W'(WIN - 1);
              cap_left   <= RC_W'(WIN);
              state      <= FILL;
            end
          end
        end

        FILL, STEP: begin
          if (issue_left != '0) begin
            o_rd_en    <= 1'b1;
            o_addr     <= base_q + rd_off;
            rd_off     <= rd_off + ADDR_W'(1);
            issue_left <= issue_left - RC_W'(1);
          end else begin
            o_rd_en <= 1'b0;
          end
          if (rd_pend) begin
            o_x      <= {o_x[XW-SW-1:0], i_rd_data};
            cap_left <= cap_left - RC_W'(1);
            if (cap_left == RC_W'(1)) begin
              state   <= EMIT;
              o_valid <= 1'b1;
            end
          end
        end

        EMIT: begin
          o_rd_en <= 1'b0;
          if (i_ready) begin
            o_valid   <= 1'b0;
            o_win_cnt <= o_win_cnt + CNT_W'(1);
            if (next_end <= {1'b0, len_q}) begin
              o_rd_en    <= 1'b1;
              o_addr     <= base_q + rd_off;
              rd_off     <= rd_off + ADDR_W'(1);
              issue_left <= RC_W'(stride_q - ADDR_W'(1));
              cap_left   <= RC_W'(stride_q);
              state      <= STEP;
            end else begin
              state  <= DONE;
              o_done <= 1'b1;
            end
          end
        end

        DONE: begin
          o_rd_en <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          o_rd_en <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
